timer_led_bus_resp: RTL and testbench

//   Ibex-style data-bus responder (core = initiator) exposing a 64-bit RISC-V machine timer
//   (mtime/mtimecmp + timer IRQ) and a 4-bit LED register. Sits on the SoC data crossbar

---
 rtl/timer_led_pkg.sv | 12 +
 rtl/timer_led_prescaler.sv | 21 ++
 rtl/timer_led_bus_resp.sv | 90 +++++++++
 tb/tb_timer_led_bus_resp.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/timer_led_pkg.sv
// timer_led_pkg: register map and field positions shared by the timer/LED bus responder.
package timer_led_pkg;
   localparam logic [4:0] OFS_MTIME_LO    = 5'h00;
   localparam logic [4:0] OFS_MTIME_HI    = 5'h04;
   localparam logic [4:0] OFS_MTIMECMP_LO = 5'h08;
   localparam logic [4:0] OFS_MTIMECMP_HI = 5'h0C;
   localparam logic [4:0] OFS_CTRL        = 5'h10;
   localparam logic [4:0] OFS_LED         = 5'h14;
   localparam int CTRL_EN        = 0;
   localparam int CTRL_PRESC_LSB = 8;
   localparam logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;
endpackage

// File: rtl/timer_led_prescaler.sv
// timer_led_prescaler: divides the clock by PRESC+1 into a one-cycle tick while enabled.
module timer_led_prescaler
   import timer_led_pkg::*;
#(
   parameter int PRESC_W = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   input  logic [PRESC_W-1:0] presc,
   output logic               tick
);
   logic [PRESC_W-1:0] cnt;

   assign tick = en & (cnt == presc);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt <= '0;
      else if (en) cnt <= tick ? '0 : cnt + 1'b1;
   end
endmodule

// File: rtl/timer_led_bus_resp.sv
// timer_led_bus_resp: data-bus responder with a 64-bit machine timer, timer IRQ and LED register.
module timer_led_bus_resp
   import timer_led_pkg::*;
#(
   parameter logic [31:0] ADDR_BASE = 32'h0002_0000,
   parameter int          PRESC_W   = 8
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        req_i,
   output logic        gnt_o,
   input  logic        we_i,
   input  logic [3:0]  be_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] wdata_i,
   output logic        rvalid_o,
   output logic [31:0] rdata_o,
   output logic        err_o,
   output logic        timer_irq_o,
   output logic [3:0]  led_o
);
   logic [31:0]        ofs, rd_val, merged, ctrl_val;
   logic [4:0]         reg_ofs;
   logic               hit, wr, tick, en, unused_ofs;
   logic [63:0]        mtime, mtimecmp;
   logic [PRESC_W-1:0] presc;

   assign ofs        = addr_i - ADDR_BASE;
   assign hit        = ofs[31:5] == '0;
   assign reg_ofs    = {ofs[4:2], 2'b00};
   assign unused_ofs = ^ofs[1:0];
   assign gnt_o      = req_i;
   assign wr         = req_i & we_i & hit;
   assign ctrl_val   = (32'(presc) << CTRL_PRESC_LSB) | 32'(en);

   always_comb begin
      rd_val = '0;
      case (reg_ofs)
         OFS_MTIME_LO:    rd_val = mtime[31:0];
         OFS_MTIME_HI:    rd_val = mtime[63:32];
         OFS_MTIMECMP_LO: rd_val = mtimecmp[31:0];
         OFS_MTIMECMP_HI: rd_val = mtimecmp[63:32];
         OFS_CTRL:        rd_val = ctrl_val;
         OFS_LED:         rd_val = {28'd0, led_o};
         default:         rd_val = '0;
      endcase
   end

   // Byte-enable merge against the current contents of the addressed register.
   for (genvar b = 0; b < 4; b++) begin : g_merge
      assign merged[8*b +: 8] = be_i[b] ? wdata_i[8*b +: 8] : rd_val[8*b +: 8];
   end

   timer_led_prescaler #(.PRESC_W(PRESC_W)) u_presc (
      .clk   (clk_i),
      .rst   (rst_i),
      .en    (en),
      .presc (presc),
      .tick  (tick)
   );

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         mtime       <= '0;
         mtimecmp    <= MTIMECMP_RST;
         en          <= 1'b0;
         presc       <= '0;
         led_o       <= '0;
         timer_irq_o <= 1'b0;
         rvalid_o    <= 1'b0;
         rdata_o     <= '0;
         err_o       <= 1'b0;
      end else begin
         if (wr && reg_ofs == OFS_MTIME_LO) mtime[31:0] <= merged;
         else if (wr && reg_ofs == OFS_MTIME_HI) mtime[63:32] <= merged;
         else if (tick) mtime <= mtime + 64'd1;
         if (wr && reg_ofs == OFS_MTIMECMP_LO) mtimecmp[31:0] <= merged;
         if (wr && reg_ofs == OFS_MTIMECMP_HI) mtimecmp[63:32] <= merged;
         if (wr && reg_ofs == OFS_CTRL) begin
            en    <= merged[CTRL_EN];
            presc <= merged[CTRL_PRESC_LSB +: PRESC_W];
         end
         if (wr && reg_ofs == OFS_LED) led_o <= merged[3:0];
         timer_irq_o <= mtime >= mtimecmp;
         rvalid_o    <= req_i;
         err_o       <= req_i & ~hit;
         rdata_o     <= (req_i & ~we_i & hit) ? rd_val : '0;
      end
   end
endmodule

// File: tb/tb_timer_led_bus_resp.sv
// tb_timer_led_bus_resp: directed checks of the timer/LED bus responder.
module tb_timer_led_bus_resp;
   import timer_led_pkg::*;
   localparam logic [31:0] B = 32'h0002_0000;

   logic        clk = 1'b0, rst = 1'b1, req = 1'b0, we = 1'b0;
   logic [3:0]  be = '0;
   logic [31:0] addr = '0, wdata = '0;
   logic        gnt, rvalid, err, irq;
   logic [31:0] rdata;
   logic [3:0]  led;
   int          checks = 0, errors = 0;

   always #5 clk = ~clk;

   timer_led_bus_resp dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .req_i       (req),
      .gnt_o       (gnt),
      .we_i        (we),
      .be_i        (be),
      .addr_i      (addr),
      .wdata_i     (wdata),
      .rvalid_o    (rvalid),
      .rdata_o     (rdata),
      .err_o       (err),
      .timer_irq_o (irq),
      .led_o       (led)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic xfer(input logic w, input logic [31:0] a, input logic [3:0] b,
                       input logic [31:0] d, output logic [31:0] r, output logic e);
      req = 1'b1; we = w; addr = a; be = b; wdata = d;
      #2;
      check("gnt", 32'(gnt), 32'd1);
      @(posedge clk);
      #1;
      req = 1'b0; we = 1'b0;
      r = rdata; e = err;
      check("rvalid", 32'(rvalid), 32'd1);
   endtask

   task automatic wr(input logic [4:0] o, input logic [3:0] b, input logic [31:0] d);
      logic [31:0] r;
      logic        e;
      xfer(1'b1, B + 32'(o), b, d, r, e);
      check("wr_err", 32'(e), 32'd0);
      check("wr_rdata", r, 32'd0);
   endtask

   task automatic rd(input logic [4:0] o, output logic [31:0] r);
      logic e;
      xfer(1'b0, B + 32'(o), 4'hF, 32'd0, r, e);
      check("rd_err", 32'(e), 32'd0);
   endtask

   initial begin
      logic [31:0] r;
      logic        e;
      repeat (2) @(posedge clk);
      #1;
      check("rst_rvalid", 32'(rvalid), 32'd0);
      check("rst_rdata", rdata, 32'd0);
      check("rst_err", 32'(err), 32'd0);
      check("rst_irq", 32'(irq), 32'd0);
      check("rst_led", 32'(led), 32'd0);
      rst = 1'b0;
      idle(1);
      rd(OFS_MTIMECMP_HI, r); check("cmp_hi_rst", r, 32'hFFFF_FFFF);
      rd(OFS_MTIME_LO, r);    check("mtime_rst", r, 32'd0);

      wr(OFS_LED, 4'b0001, 32'h0000_000A); check("led_a", 32'(led), 32'hA);
      wr(OFS_LED, 4'b0000, 32'h0000_0005); check("led_be0", 32'(led), 32'hA);

      wr(OFS_CTRL, 4'hF, 32'h0000_0301);
      idle(15);
      wr(OFS_CTRL, 4'b0001, 32'h0);
      rd(OFS_MTIME_LO, r); check("presc3", r, 32'd4);
      rd(OFS_CTRL, r);     check("ctrl_be", r, 32'h0000_0300);
      idle(5);
      rd(OFS_MTIME_LO, r); check("frozen", r, 32'd4);

      wr(OFS_MTIME_LO, 4'hF, 32'h0);
      wr(OFS_CTRL, 4'hF, 32'h1);
      idle(9);
      wr(OFS_CTRL, 4'hF, 32'h0);
      rd(OFS_MTIME_LO, r); check("presc0", r, 32'd10);

      wr(OFS_MTIME_LO, 4'b0100, 32'h1122_3344);
      rd(OFS_MTIME_LO, r); check("be_merge", r, 32'h0022_000A);

      wr(OFS_MTIME_LO, 4'hF, 32'hFFFF_FFFF);
      wr(OFS_MTIME_HI, 4'hF, 32'h0);
      wr(OFS_CTRL, 4'hF, 32'h1);
      wr(OFS_CTRL, 4'hF, 32'h0);
      rd(OFS_MTIME_LO, r); check("carry_lo", r, 32'd0);
      rd(OFS_MTIME_HI, r); check("carry_hi", r, 32'd1);

      wr(OFS_MTIME_LO, 4'hF, 32'hFFFF_FFFF);
      wr(OFS_MTIME_HI, 4'hF, 32'hFFFF_FFFF);
      wr(OFS_CTRL, 4'hF, 32'h1);
      wr(OFS_CTRL, 4'hF, 32'h0);
      rd(OFS_MTIME_LO, r); check("wrap_lo", r, 32'd0);
      rd(OFS_MTIME_HI, r); check("wrap_hi", r, 32'd0);

      wr(OFS_CTRL, 4'hF, 32'h1);
      wr(OFS_MTIME_LO, 4'hF, 32'h50);
      wr(OFS_CTRL, 4'hF, 32'h0);
      rd(OFS_MTIME_LO, r); check("wr_wins", r, 32'h51);
      rd(OFS_MTIME_HI, r); check("wr_wins_hi", r, 32'd0);

      wr(OFS_MTIMECMP_LO, 4'hF, 32'd100);
      wr(OFS_MTIMECMP_HI, 4'hF, 32'd0);
      wr(OFS_MTIME_LO, 4'hF, 32'd98);
      idle(1);
      check("irq_low", 32'(irq), 32'd0);
      wr(OFS_CTRL, 4'hF, 32'h1);
      check("irq_98", 32'(irq), 32'd0);
      idle(2);
      check("irq_at100", 32'(irq), 32'd0);
      idle(1);
      check("irq_rise", 32'(irq), 32'd1);
      wr(OFS_MTIMECMP_LO, 4'hF, 32'd200);
      check("irq_hold", 32'(irq), 32'd1);
      idle(1);
      check("irq_fall", 32'(irq), 32'd0);
      wr(OFS_CTRL, 4'hF, 32'h0);

      req = 1'b1; we = 1'b0; be = 4'hF; addr = B;
      @(posedge clk); #1;
      check("b2b_v1", 32'(rvalid), 32'd1);
      check("b2b_e1", 32'(err), 32'd0);
      check("b2b_d1", rdata, 32'd104);
      addr = B + 32'h40;
      @(posedge clk); #1;
      req = 1'b0;
      check("b2b_v2", 32'(rvalid), 32'd1);
      check("b2b_e2", 32'(err), 32'd1);
      check("b2b_d2", rdata, 32'd0);
      idle(1);
      check("b2b_idle", 32'(rvalid), 32'd0);

      rd(5'h18, r); check("rsvd", r, 32'd0);
      xfer(1'b1, B + 32'h20, 4'hF, 32'hF, r, e);
      check("oob_err", 32'(e), 32'd1);
      check("oob_led", 32'(led), 32'hA);
      xfer(1'b0, B - 32'd4, 4'hF, 32'h0, r, e);
      check("below_err", 32'(e), 32'd1);
      check("below_rdata", r, 32'd0);

      wr(OFS_MTIMECMP_LO, 4'hF, 32'd0);
      idle(1);
      check("irq_pre_rst", 32'(irq), 32'd1);

      req = 1'b1; we = 1'b0; addr = B + 32'(OFS_LED);
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      req = 1'b0;
      check("mid_rvalid", 32'(rvalid), 32'd0);
      check("mid_irq", 32'(irq), 32'd0);
      check("mid_led", 32'(led), 32'd0);
      idle(1);
      rst = 1'b0;
      idle(3);
      check("post_rvalid", 32'(rvalid), 32'd0);
      rd(OFS_MTIMECMP_HI, r); check("post_cmp_hi", r, 32'hFFFF_FFFF);
      rd(OFS_CTRL, r);        check("post_ctrl", r, 32'd0);
      rd(OFS_MTIME_LO, r);    check("post_mtime", r, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
